bus_timer: RTL
==============

# bus_timer

Memory-mapped 32-bit timer follower that sits downstream of `system_bus` on one follower port. It is selected when the leader address region `addr[31:28]` equals that port's index + 1. It provides:
- a free-running or auto-reloading up-counter;
- a compare match with a sticky status flag;
- a registered interrupt line to the core.

## Interface
- `Prescale` (default 0): reset value of the prescaler divisor field; only meaningful with `TIMER_PRESCALER_EN`.
- `clk  in  1`: system clock; all state changes on its rising edge.
- `reset_n  in  1`: asynchronous, active-low reset.
- `bus  bus.follower  -`: follower side of the system bus.
  - Inputs: `addr[31:0]`, `write_data[31:0]`, `byte_enable[3:0]`, `read_req`, `write_req`.
  - Outputs: `read_data[31:0]`, `read_data_valid`.
- `irq  out  1`: registered timer interrupt, level-sensitive.

## Operation
- Decodes `addr[3:2]` only; all other address bits are ignored.
- Register map:
  - 0x0 CTRL
    - bit0 EN; bit1 AUTO_RELOAD; bit2 IRQ_EN.
    - bits[15:8] PRESCALE, only with `TIMER_PRESCALER_EN`.
    - All other bits read 0.
  - 0x4 COUNT: current counter value, read/write.
  - 0x8 COMPARE: compare value, read/write.
  - 0xC STATUS: bit0 MATCH, sticky, write-1-to-clear; all other bits read 0.
- Writes:
  - CTRL, COUNT and COMPARE are updated per byte where `byte_enable[n]` is set.
  - STATUS clear uses byte lane 0 only.
  - A write with `byte_enable` = 0 has no effect.
- Tick: one clock when EN = 1; never when EN = 0.
- On each tick:
  - If COUNT == COMPARE: MATCH is set, and COUNT becomes 0 if AUTO_RELOAD = 1, otherwise COUNT+1.
  - Otherwise COUNT becomes COUNT+1.
- Counter arithmetic is modulo 2^32: 0xFFFF_FFFF wraps to 0 with no flag.
- `irq` is registered: `irq` <= MATCH & IRQ_EN.
- Simultaneous events:
  - Bus write to COUNT in the same cycle as a tick: the write wins and the tick increment is discarded. A match evaluated that cycle still sets MATCH.
  - MATCH set and W1C in the same cycle: set wins and MATCH stays 1.
  - `read_req` and `write_req` together: the write is performed, and the read returns the pre-write value.
  - EN cleared by a write: ticks stop starting the next cycle.
- Reset (any time, including mid-count):
  - CTRL = 0, COUNT = 0, COMPARE = 0xFFFF_FFFF, MATCH = 0.
  - Outputs: `irq` = 0, `read_data` = 0, `read_data_valid` = 0.
  - Prescaler counter = 0.

## Timing
- Read latency is 1 cycle:
  - `read_req` high in cycle N gives `read_data_valid` = 1 for exactly cycle N+1, with `read_data` holding the register value sampled at cycle N.
  - `read_data` is 0 whenever `read_data_valid` = 0, which the bus OR/priority merge requires.
- Back-to-back reads every cycle are supported, with one response per request.
- Writes take effect at the rising edge ending the request cycle and are visible to a read issued the next cycle.
- No stall or backpressure exists: every request is accepted in the cycle presented.
- `irq` lags the MATCH register by 1 cycle and the matching tick by 2 cycles.

## Configuration
- `TIMER_PRESCALER_EN` defined:
  - CTRL[15:8] holds PRESCALE P, reset value `Prescale`.
  - A tick occurs once every P+1 enabled clocks.
  - The prescaler counter resets to 0 on any CTRL write and while EN = 0.
- Undefined:
  - Every enabled clock is a tick.
  - CTRL[15:8] reads 0 and writes to it are ignored.

## Structure
- `timer_pkg` holds:
  - register offset constants: `TIMER_CTRL`, `TIMER_COUNT`, `TIMER_COMPARE`, `TIMER_STATUS`;
  - CTRL bit-position constants;
  - the COMPARE reset constant.
- Sub-module `timer_prescaler`, instantiated only under the macro:
  - inputs: `clk`, `reset_n`, `enable`, `restart`, `divisor[7:0]`;
  - output: `tick`.

## Test plan
- Reset then read all four registers: CTRL=0, COUNT=0, COMPARE=0xFFFF_FFFF, STATUS=0, each with `read_data_valid` one cycle after `read_req`.
- COMPARE=5, CTRL=0x7: MATCH=1 on the 6th tick, COUNT returns to 0, `irq` high 1 cycle after MATCH, then STATUS W1C 0x1 drops `irq` the following cycle.
- COUNT=0xFFFF_FFFE, COMPARE=0x10, CTRL=0x1: COUNT reads 0xFFFF_FFFF then 0, with MATCH staying 0.
- Byte write of COMPARE with `byte_enable`=4'b0010 and data 0xAABBCCDD: COMPARE = 0xFFFF_CCFF.
- Tick-aligned write of COUNT=0x100: the next read shows 0x100; STATUS W1C on the match cycle: MATCH reads 1.
- With the macro, P=3: COUNT increments once per 4 clocks; async `reset_n` pulse mid-count: all outputs 0 immediately.

Source files
------------

// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - register offsets, CTRL bit positions and helpers for bus_timer
package timer_pkg;

   localparam logic [3:0] TIMER_CTRL    = 4'h0;
   localparam logic [3:0] TIMER_COUNT   = 4'h4;
   localparam logic [3:0] TIMER_COMPARE = 4'h8;
   localparam logic [3:0] TIMER_STATUS  = 4'hC;

   localparam int CTRL_EN_BIT          = 0;
   localparam int CTRL_AUTO_RELOAD_BIT = 1;
   localparam int CTRL_IRQ_EN_BIT      = 2;
   localparam int CTRL_PRESCALE_LSB    = 8;

   localparam logic [31:0] COMPARE_RESET = 32'hFFFF_FFFF;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  be);
      logic [31:0] w_res;
      w_res = old_v;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) w_res[i*8 +: 8] = new_v[i*8 +: 8];
      end
      return w_res;
   endfunction

endpackage

// File: rtl/bus_timer_if.sv
// rtl/bus_timer_if.sv - system bus follower-port signals seen by bus_timer
interface bus_timer_if;
   logic [31:0] addr;
   logic [31:0] write_data;
   logic [3:0]  byte_enable;
   logic        read_req;
   logic        write_req;
   logic [31:0] read_data;
   logic        read_data_valid;

   modport follower (
      input  addr, write_data, byte_enable, read_req, write_req,
      output read_data, read_data_valid
   );

   modport leader (
      output addr, write_data, byte_enable, read_req, write_req,
      input  read_data, read_data_valid
   );
endinterface

// File: rtl/timer_prescaler.sv
// rtl/timer_prescaler.sv - divides enabled clocks by divisor+1 into single-cycle ticks
module timer_prescaler (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       enable,
   input  logic       restart,
   input  logic [7:0] divisor,
   output logic       tick
);

   logic [7:0] r_cnt;
   logic       w_wrap;

   assign w_wrap = (r_cnt == divisor);
   assign tick   = enable && w_wrap;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt <= 8'd0;
      end else if (!enable || restart || w_wrap) begin
         r_cnt <= 8'd0;
      end else begin
         r_cnt <= r_cnt + 8'd1;
      end
   end

endmodule

// File: rtl/bus_timer.sv
// rtl/bus_timer.sv - memory-mapped 32-bit compare timer; TIMER_PRESCALER_EN adds a tick prescaler
module bus_timer
   import timer_pkg::*;
#(
   parameter logic [7:0] Prescale = 8'd0
) (
   input  logic                 clk,
   input  logic                 reset_n,
   bus_timer_if.follower        bus,
   output logic                 irq
);

   logic        r_en, r_auto, r_irq_en;
   logic [31:0] r_count, r_compare;
   logic        r_match, r_irq;
   logic [31:0] r_rdata;
   logic        r_rvalid;

   logic [3:0]  w_off;
   logic        w_wr, w_wr_ctrl, w_wr_count, w_wr_compare, w_wr_status;
   logic        w_tick, w_hit;
   logic [7:0]  w_prescale_rd;
   logic [31:0] w_rd_mux;
   logic        w_unused;

   assign w_off        = {bus.addr[3:2], 2'b00};
   assign w_wr         = bus.write_req && (bus.byte_enable != 4'b0000);
   assign w_wr_ctrl    = w_wr && (w_off == TIMER_CTRL);
   assign w_wr_count   = w_wr && (w_off == TIMER_COUNT);
   assign w_wr_compare = w_wr && (w_off == TIMER_COMPARE);
   assign w_wr_status  = w_wr && (w_off == TIMER_STATUS);

`ifdef TIMER_PRESCALER_EN
   logic [7:0] r_prescale;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_prescale <= Prescale;
      end else if (w_wr_ctrl && bus.byte_enable[1]) begin
         r_prescale <= bus.write_data[CTRL_PRESCALE_LSB +: 8];
      end
   end

   timer_prescaler u_prescaler (
      .clk     (clk),
      .reset_n (reset_n),
      .enable  (r_en),
      .restart (w_wr_ctrl),
      .divisor (r_prescale),
      .tick    (w_tick)
   );

   assign w_prescale_rd = r_prescale;
   assign w_unused      = ^{bus.addr[31:4], bus.addr[1:0]};
`else
   assign w_tick        = r_en;
   assign w_prescale_rd = 8'd0;
   assign w_unused      = ^{bus.addr[31:4], bus.addr[1:0], Prescale};
`endif

   assign w_hit = w_tick && (r_count == r_compare);

   always_comb begin
      w_rd_mux = 32'd0;
      case (w_off)
         TIMER_CTRL:    w_rd_mux = {16'd0, w_prescale_rd, 5'd0, r_irq_en, r_auto, r_en};
         TIMER_COUNT:   w_rd_mux = r_count;
         TIMER_COMPARE: w_rd_mux = r_compare;
         TIMER_STATUS:  w_rd_mux = {31'd0, r_match};
         default:       w_rd_mux = 32'd0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_en      <= 1'b0;
         r_auto    <= 1'b0;
         r_irq_en  <= 1'b0;
         r_count   <= 32'd0;
         r_compare <= COMPARE_RESET;
         r_match   <= 1'b0;
         r_irq     <= 1'b0;
         r_rdata   <= 32'd0;
         r_rvalid  <= 1'b0;
      end else begin
         if (w_wr_ctrl && bus.byte_enable[0]) begin
            r_en     <= bus.write_data[CTRL_EN_BIT];
            r_auto   <= bus.write_data[CTRL_AUTO_RELOAD_BIT];
            r_irq_en <= bus.write_data[CTRL_IRQ_EN_BIT];
         end
         // A bus write to COUNT overrides the tick, but the match still registers.
         if (w_wr_count) begin
            r_count <= merge_bytes(r_count, bus.write_data, bus.byte_enable);
         end else if (w_tick) begin
            r_count <= (w_hit && r_auto) ? 32'd0 : r_count + 32'd1;
         end
         if (w_wr_compare) begin
            r_compare <= merge_bytes(r_compare, bus.write_data, bus.byte_enable);
         end
         if (w_hit) begin
            r_match <= 1'b1;
         end else if (w_wr_status && bus.byte_enable[0] && bus.write_data[0]) begin
            r_match <= 1'b0;
         end
         r_irq    <= r_match && r_irq_en;
         r_rvalid <= bus.read_req;
         // Zero when idle so the upstream OR-merge of follower responses stays clean.
         r_rdata  <= bus.read_req ? w_rd_mux : 32'd0;
      end
   end

   assign bus.read_data       = r_rdata;
   assign bus.read_data_valid = r_rvalid;
   assign irq                 = r_irq;

endmodule
